// File: rtl/nibble_alu_pkg.sv
// rtl/nibble_alu_pkg.sv - shared op, flag and state types for the nibble ALU
package nibble_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBC  = 4'h3,
        OP_AND  = 4'h4,
        OP_XOR  = 4'h5,
        OP_OR   = 4'h6,
        OP_CP   = 4'h7,
        OP_RLC  = 4'h8,
        OP_RRC  = 4'h9,
        OP_RL   = 4'hA,
        OP_RR   = 4'hB,
        OP_SLA  = 4'hC,
        OP_SRA  = 4'hD,
        OP_SWAP = 4'hE,
        OP_SRL  = 4'hF
    } alu_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(alu_op_t op);
        return op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP};
    endfunction

    function automatic logic is_sub(alu_op_t op);
        return op inside {OP_SUB, OP_SBC, OP_CP};
    endfunction

endpackage

// File: rtl/nibble_alu_nibble.sv
// rtl/nibble_alu_nibble.sv - combinational 4-bit add/subtract slice with carry/borrow
module alu_nibble (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_sub,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [4:0] w_sum;

    // For subtraction, bit 4 of the 5-bit difference is the borrow out.
    always_comb begin
        if (i_sub) begin
            w_sum = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_cin};
        end else begin
            w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
        end
    end

    assign o_s    = w_sum[3:0];
    assign o_cout = w_sum[4];

endmodule

// File: rtl/nibble_alu.sv
// rtl/nibble_alu.sv - nibble-serial arithmetic / single-cycle logic and shift ALU
module nibble_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic             cf_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zf_out,
    output logic             nf_out,
    output logic             hf_out,
    output logic             cf_out
);
    import nibble_alu_pkg::*;

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(NIB - 2);

    state_t           r_state, w_next;
    alu_op_t          r_op, w_op;
    logic [WIDTH-1:0] r_lhs, r_a, r_b, r_acc, r_r;
    logic [WIDTH-1:0] w_imm_r, w_full;
    logic             r_carry, r_h;
    logic [CW-1:0]    r_cnt;
    flags_t           r_flags, w_imm_f, w_arith_f;
    logic [3:0]       w_s;
    logic             w_cout, w_accept, w_step, w_last;

    assign w_op     = alu_op_t'(op);
    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;
    assign w_step   = (r_state == ST_BUSY) && !flush;
    assign w_last   = (r_cnt == CNT_LAST);

    alu_nibble u_nibble (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_sub  (is_sub(r_op)),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Result nibbles enter at the top and shift down, so after NIB steps nibble 0 sits at the bottom.
    assign w_full    = {w_s, r_acc[WIDTH-1:4]};
    assign w_arith_f = '{z: (w_full == '0), n: is_sub(r_op), h: r_h, c: w_cout};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = is_arith(w_op) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (flush) w_next = ST_IDLE;
                     else if (w_last) w_next = ST_DONE;
            ST_DONE: if (flush || out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_imm_r = '0;
        w_imm_f = '0;
        case (w_op)
            OP_AND:  begin w_imm_r = lhs & rhs; w_imm_f.h = 1'b1; end
            OP_XOR:  w_imm_r = lhs ^ rhs;
            OP_OR:   w_imm_r = lhs | rhs;
            OP_RLC:  begin w_imm_r = {lhs[WIDTH-2:0], lhs[WIDTH-1]}; w_imm_f.c = lhs[WIDTH-1]; end
            OP_RRC:  begin w_imm_r = {lhs[0], lhs[WIDTH-1:1]};       w_imm_f.c = lhs[0]; end
            OP_RL:   begin w_imm_r = {lhs[WIDTH-2:0], cf_in};        w_imm_f.c = lhs[WIDTH-1]; end
            OP_RR:   begin w_imm_r = {cf_in, lhs[WIDTH-1:1]};        w_imm_f.c = lhs[0]; end
            OP_SLA:  begin w_imm_r = {lhs[WIDTH-2:0], 1'b0};         w_imm_f.c = lhs[WIDTH-1]; end
            OP_SRA:  begin w_imm_r = {lhs[WIDTH-1], lhs[WIDTH-1:1]}; w_imm_f.c = lhs[0]; end
            OP_SWAP: w_imm_r = {lhs[WIDTH/2-1:0], lhs[WIDTH-1:WIDTH/2]};
            OP_SRL:  begin w_imm_r = {1'b0, lhs[WIDTH-1:1]};         w_imm_f.c = lhs[0]; end
            default: w_imm_r = '0;
        endcase
        w_imm_f.z = (w_imm_r == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_ADD;
            r_lhs   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_r     <= '0;
            r_carry <= 1'b0;
            r_h     <= 1'b0;
            r_cnt   <= '0;
            r_flags <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_lhs   <= lhs;
                r_a     <= lhs;
                r_b     <= rhs;
                r_acc   <= '0;
                r_carry <= cf_in && (w_op == OP_ADC || w_op == OP_SBC);
                r_h     <= 1'b0;
                r_cnt   <= '0;
                if (!is_arith(w_op)) begin
                    r_r     <= w_imm_r;
                    r_flags <= w_imm_f;
                end
            end
            if (w_step) begin
                r_a     <= r_a >> 4;
                r_b     <= r_b >> 4;
                r_acc   <= w_full;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                // Half carry is the carry out of the second-highest nibble.
                if (r_cnt == CNT_HALF) r_h <= w_cout;
                if (w_last) begin
                    r_r     <= (r_op == OP_CP) ? r_lhs : w_full;
                    r_flags <= w_arith_f;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign r         = r_r;
    assign zf_out    = r_flags.z;
    assign nf_out    = r_flags.n;
    assign hf_out    = r_flags.h;
    assign cf_out    = r_flags.c;

endmodule

// File: tb/tb_nibble_alu.sv
// tb/tb_nibble_alu.sv - scoreboard bench for 8-bit and 16-bit nibble_alu instances
module tb_nibble_alu;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    logic        in_valid[2], flush[2], out_ready[2], cf_in[2];
    logic [3:0]  op[2];
    logic [15:0] lhs[2], rhs[2];
    logic        ov[2], ir[2], zf[2], nf[2], hf[2], cf[2];
    logic [7:0]  r0;
    logic [15:0] r1;
    logic [15:0] o_r[2];

    exp_t        q0[$], q1[$];
    exp_t        cur[2];
    logic        have_cur[2];

    assign o_r[0] = {8'h00, r0};
    assign o_r[1] = r1;

    always @(posedge clk) cyc <= cyc + 1;

    nibble_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir[0]), .op(op[0]),
        .lhs(lhs[0][7:0]), .rhs(rhs[0][7:0]), .cf_in(cf_in[0]), .flush(flush[0]),
        .out_valid(ov[0]), .out_ready(out_ready[0]), .r(r0),
        .zf_out(zf[0]), .nf_out(nf[0]), .hf_out(hf[0]), .cf_out(cf[0])
    );

    nibble_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir[1]), .op(op[1]),
        .lhs(lhs[1]), .rhs(rhs[1]), .cf_in(cf_in[1]), .flush(flush[1]),
        .out_valid(ov[1]), .out_ready(out_ready[1]), .r(r1),
        .zf_out(zf[1]), .nf_out(nf[1]), .hf_out(hf[1]), .cf_out(cf[1])
    );

    function automatic logic [3:0] flg(int k);
        return {zf[k], nf[k], hf[k], cf[k]};
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, k, act, req, $time);
        end
    endtask

    function automatic exp_t mk(logic [15:0] r, logic [3:0] f, int lat);
        exp_t e;
        e.r = r; e.f = f; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    // Reference: whole-word integer arithmetic; half carry from the low (w-4) bits.
    function automatic exp_t model(int w, logic [3:0] o, logic [15:0] a, logic [15:0] b, logic c);
        longint la, lb, mask, lm, ci, t, ht, res, zsrc, msb, lsb;
        logic   h, cy, n;
        exp_t   e;
        mask = (64'd1 << w) - 1;
        lm   = (64'd1 << (w - 4)) - 1;
        la   = longint'(a) & mask;
        lb   = longint'(b) & mask;
        ci   = 0; t = 0; ht = 0; res = 0;
        msb  = (la >> (w - 1)) & 1;
        lsb  = la & 1;
        h = 1'b0; cy = 1'b0; n = 1'b0;
        e.lat = 1;
        case (o)
            4'd0, 4'd1: begin
                ci = (o == 4'd1) ? longint'(c) : 0;
                t = la + lb + ci; ht = (la & lm) + (lb & lm) + ci;
                res = t & mask; cy = ((t >> w) & 1) != 0; h = ((ht >> (w - 4)) & 1) != 0;
                e.lat = w / 4 + 1;
            end
            4'd2, 4'd3, 4'd7: begin
                ci = (o == 4'd3) ? longint'(c) : 0;
                t = la - lb - ci; ht = (la & lm) - (lb & lm) - ci;
                res = t & mask; cy = (t < 0); h = (ht < 0); n = 1'b1;
                e.lat = w / 4 + 1;
            end
            4'd4: begin res = la & lb; h = 1'b1; end
            4'd5: res = la ^ lb;
            4'd6: res = la | lb;
            4'd8: begin res = ((la << 1) | msb) & mask;                  cy = msb != 0; end
            4'd9: begin res = (la >> 1) | (lsb << (w - 1));              cy = lsb != 0; end
            4'hA: begin res = ((la << 1) | longint'(c)) & mask;          cy = msb != 0; end
            4'hB: begin res = (la >> 1) | (longint'(c) << (w - 1));      cy = lsb != 0; end
            4'hC: begin res = (la << 1) & mask;                          cy = msb != 0; end
            4'hD: begin res = (la >> 1) | (msb << (w - 1));              cy = lsb != 0; end
            4'hE: res = ((la << (w / 2)) | (la >> (w / 2))) & mask;
            default: begin res = la >> 1;                                cy = lsb != 0; end
        endcase
        zsrc = res;
        if (o == 4'd7) res = la;
        e.r   = res[15:0];
        e.f   = {zsrc == 0, n, h, cy};
        e.cyc = 0;
        return e;
    endfunction

    task automatic mon(int k);
        exp_t e;
        if (!rst_n || !ov[k]) begin
            have_cur[k] = 1'b0;
            return;
        end
        check("in_ready_in_done", k, 32'(ir[k]), 32'd0);
        if (!have_cur[k]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out_valid dut%0d actual=1 required=0 t=%0t", k, $time);
                cur[k] = mk(o_r[k], flg(k), 0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check("result", k, 32'(o_r[k]), 32'(e.r));
                check("flags", k, 32'(flg(k)), 32'(e.f));
                check("latency", k, cyc, e.cyc);
                cur[k] = e;
            end
            have_cur[k] = 1'b1;
        end else begin
            check("hold_result", k, 32'(o_r[k]), 32'(cur[k].r));
            check("hold_flags", k, 32'(flg(k)), 32'(cur[k].f));
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called at a negedge; returns 1ns after the accept edge with inputs scrambled.
    task automatic send(int k, logic [3:0] o, logic [15:0] a, logic [15:0] b, logic c,
                        logic push, exp_t e);
        int n = 0;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            check("in_ready_wait", k, 32'(ir[k]), 32'd1);
            return;
        end
        in_valid[k] = 1'b1; op[k] = o; lhs[k] = a; rhs[k] = b; cf_in[k] = c;
        if (push) begin
            e.cyc = cyc + e.lat;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        op[k]    = 4'($urandom);
        lhs[k]   = 16'($urandom);
        rhs[k]   = 16'($urandom);
        cf_in[k] = 1'($urandom);
    endtask

    task automatic issue(int k, logic [3:0] o, logic [15:0] a, logic [15:0] b, logic c,
                         exp_t e, int hold);
        int n = 0;
        send(k, o, a, b, c, 1'b1, e);
        @(negedge clk);
        while (!ov[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ov[k]) begin
            check("out_valid_wait", k, 32'(ov[k]), 32'd1);
            return;
        end
        repeat (hold) @(negedge clk);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("idle_after_handshake", k, 32'({ov[k], ir[k]}), 32'd1);
    endtask

    initial begin
        exp_t ez;
        ez = mk(16'h0, 4'h0, 0);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b0; cf_in[k] = 1'b0;
            op[k] = 4'h0; lhs[k] = 16'h0; rhs[k] = 16'h0; have_cur[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_out_valid", k, 32'(ov[k]), 32'd0);
            check("reset_result", k, 32'(o_r[k]), 32'd0);
            check("reset_flags", k, 32'(flg(k)), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("in_ready_after_reset", k, 32'(ir[k]), 32'd1);

        issue(0, 4'h0, 16'h00FF, 16'h0001, 1'b0, mk(16'h0000, 4'b1011, 3), 0);
        issue(0, 4'h2, 16'h0010, 16'h0001, 1'b0, mk(16'h000F, 4'b0110, 3), 0);
        issue(0, 4'h7, 16'h0010, 16'h0001, 1'b0, mk(16'h0010, 4'b0110, 3), 0);
        issue(1, 4'h0, 16'h0FFF, 16'h0001, 1'b0, mk(16'h1000, 4'b0010, 5), 0);
        issue(1, 4'h3, 16'h0000, 16'h0000, 1'b1, mk(16'hFFFF, 4'b0111, 5), 0);
        issue(0, 4'hA, 16'h0080, 16'h0000, 1'b0, mk(16'h0000, 4'b1001, 1), 0);
        issue(0, 4'hE, 16'h00A5, 16'h0000, 1'b0, mk(16'h005A, 4'b0000, 1), 0);
        issue(0, 4'h4, 16'h00F0, 16'h003C, 1'b0, mk(16'h0030, 4'b0010, 1), 5);
        issue(0, 4'h5, 16'h000F, 16'h00F0, 1'b0, mk(16'h00FF, 4'b0000, 1), 0);

        // flush in the second BUSY cycle of a 16-bit add
        send(1, 4'h0, 16'h1234, 16'h4321, 1'b0, 1'b0, ez);
        @(negedge clk);
        @(negedge clk);
        flush[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        check("flush_to_idle", 1, 32'({ov[1], ir[1]}), 32'd1);
        repeat (6) @(negedge clk);
        issue(1, 4'h2, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 4'b0110, 5), 0);

        // flush together with in_valid in IDLE must block the accept
        in_valid[0] = 1'b1; flush[0] = 1'b1; op[0] = 4'h4; lhs[0] = 16'h00FF; rhs[0] = 16'h00FF;
        @(negedge clk);
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        check("flush_blocks_accept", 0, 32'(ir[0]), 32'd1);
        repeat (3) @(negedge clk);

        // reset while BUSY discards the request
        send(1, 4'h1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, ez);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_result", 1, 32'(o_r[1]), 32'd0);
        check("midreset_flags", 1, 32'(flg(1)), 32'd0);
        check("midreset_idle", 1, 32'({ov[1], ir[1]}), 32'd1);
        repeat (6) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [3:0]  ro;
                logic [15:0] ra, rb;
                logic        rc;
                ro = 4'($urandom);
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                issue(k, ro, ra, rb, rc, model(k == 0 ? 8 : 16, ro, ra, rb, rc),
                      int'($urandom_range(0, 3)));
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 0, 32'(q0.size()), 32'd0);
        check("queue_drained", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
